// File: rtl/irq_ctrl_param.sv
// Parameterised interrupt controller.
// Each source can be level or rising-edge triggered. A two-state FSM presents
// one source at a time and holds it until it is acknowledged. Arbitration is
// fixed priority (index 0 highest) or round-robin.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | nothing presented; the next edge loads a winner if any is eligible
// S_ACTIVE | irq_out high, irq_id frozen until irq_ack
//
// The reset input is named rstn but it is active-high.
module irq_ctrl_param #(
  parameter  int NUM_IRQ   = 8,
  parameter  int PRIO_MODE = 0,
  localparam int ID_W      = ($clog2(NUM_IRQ) > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_IRQ-1:0] irq_requests,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic [NUM_IRQ-1:0] irq_edge,
  input  logic               irq_ack,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] irq_overflow
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  // One extra bit so that base + offset cannot overflow before the wrap.
  localparam logic [ID_W:0]   NUM_W   = (ID_W+1)'(NUM_IRQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_IRQ - 1);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [NUM_IRQ-1:0] r_req_q;
  logic [NUM_IRQ-1:0] r_pend_lat;
  logic [NUM_IRQ-1:0] r_ovf;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_rr_ptr;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_ack_clr;
  logic [NUM_IRQ-1:0] w_lat_nxt;
  logic [NUM_IRQ-1:0] w_ovf_nxt;

  logic [ID_W-1:0]      w_base;
  logic [2*NUM_IRQ-1:0] w_dbl;
  logic [NUM_IRQ-1:0]   w_rot;
  logic [ID_W-1:0]      w_off;
  logic [ID_W:0]        w_sum;
  logic [ID_W:0]        w_wrap;
  logic [ID_W-1:0]      w_win_id;
  logic                 w_win_vld;
  logic [ID_W-1:0]      w_rr_nxt;

  logic w_load;
  logic w_ack_fire;

  // Because req_q resets to 0, any input already high when reset is released
  // is seen as a rising edge.
  assign w_rise = irq_requests & ~r_req_q;

  // Edge sources report their latch. Level sources report the raw request line.
  assign w_pending  = (irq_edge & r_pend_lat) | (~irq_edge & irq_requests);
  assign w_eligible = w_pending & irq_enable;

  // Decode which source is being acknowledged this cycle (one-hot or zero).
  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_ack_clr[i] = w_ack_fire && (r_id == ID_W'(i));
    end
  end

  // Next value of the pending latches and overflow flags.
  // A new edge on the cycle of its own acknowledge re-arms the latch and is
  // not counted as lost.
  always_comb begin
    w_lat_nxt = r_pend_lat;
    w_ovf_nxt = r_ovf;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_edge[i]) begin
        if (w_rise[i]) begin
          w_lat_nxt[i] = 1'b1;
        end else if (w_ack_clr[i]) begin
          w_lat_nxt[i] = 1'b0;
        end
        if (w_rise[i] && r_pend_lat[i] && !w_ack_clr[i]) begin
          w_ovf_nxt[i] = 1'b1;
        end else if (w_ack_clr[i]) begin
          w_ovf_nxt[i] = 1'b0;
        end
      end else begin
        w_lat_nxt[i] = 1'b0;
        if (w_ack_clr[i]) begin
          w_ovf_nxt[i] = 1'b0;
        end
      end
    end
  end

  // Fixed priority is round-robin with the search base tied to 0.
  assign w_base = (PRIO_MODE == 1) ? r_rr_ptr : '0;
  assign w_dbl  = {w_eligible, w_eligible} >> w_base;
  assign w_rot  = w_dbl[NUM_IRQ-1:0];

  // Find the lowest set bit of the rotated eligible vector.
  always_comb begin
    w_win_vld = 1'b0;
    w_off     = '0;
    for (int j = NUM_IRQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_win_vld = 1'b1;
        w_off     = ID_W'(j);
      end
    end
  end

  // Map the rotated offset back to a source index, modulo NUM_IRQ.
  always_comb begin
    w_sum  = {1'b0, w_base} + {1'b0, w_off};
    w_wrap = w_sum;
    if (w_sum >= NUM_W) begin
      w_wrap = w_sum - NUM_W;
    end
  end

  assign w_win_id = w_wrap[ID_W-1:0];
  assign w_rr_nxt = (r_id == LAST_ID) ? '0 : (r_id + 1'b1);

  // FSM next state. An acknowledge is acted on only while something is
  // presented, so the FSM always passes through IDLE between presentations.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ack_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = S_ACTIVE;
          w_load      = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (irq_ack) begin
          w_state_nxt = S_IDLE;
          w_ack_fire  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request history, pending latches and overflow flags.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_req_q    <= '0;
      r_pend_lat <= '0;
      r_ovf      <= '0;
    end else begin
      r_req_q    <= irq_requests;
      r_pend_lat <= w_lat_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  // Presented id is captured on entry to ACTIVE. The round-robin pointer
  // advances past the source that was just acknowledged.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_load) begin
        r_id <= w_win_id;
      end
      if (w_ack_fire) begin
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  assign irq_out      = (r_state == S_ACTIVE);
  assign irq_id       = r_id;
  assign irq_pending  = w_pending;
  assign irq_overflow = r_ovf;

endmodule

// File: tb/tb_irq_ctrl_param.sv
// Bench for irq_ctrl_param with NUM_IRQ = 8.
// One instance uses fixed priority and one uses round-robin; both share the stimulus.
module tb_irq_ctrl_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] en;
  logic [7:0] edg;
  logic       ack;

  logic       f_out;
  logic [2:0] f_id;
  logic [7:0] f_pend;
  logic [7:0] f_ovf;
  logic       r_out;
  logic [2:0] r_id;
  logic [7:0] r_pend;
  logic [7:0] r_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] en;
    logic [7:0] edg;
    logic       ack;
    logic       out;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] ovf;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  irq_ctrl_param #(.NUM_IRQ(8), .PRIO_MODE(0)) u_fix (
    .clk          (clk),
    .rstn         (rst),
    .irq_requests (req),
    .irq_enable   (en),
    .irq_edge     (edg),
    .irq_ack      (ack),
    .irq_out      (f_out),
    .irq_id       (f_id),
    .irq_pending  (f_pend),
    .irq_overflow (f_ovf)
  );

  irq_ctrl_param #(.NUM_IRQ(8), .PRIO_MODE(1)) u_rr (
    .clk          (clk),
    .rstn         (rst),
    .irq_requests (req),
    .irq_enable   (en),
    .irq_edge     (edg),
    .irq_ack      (ack),
    .irq_out      (r_out),
    .irq_id       (r_id),
    .irq_pending  (r_pend),
    .irq_overflow (r_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] e, input logic [7:0] g,
                     input logic a, input logic o, input logic [2:0] i,
                     input logic [7:0] p, input logic [7:0] v);
    vec_t t;
    t.req = r; t.en = e; t.edg = g; t.ack = a;
    t.out = o; t.id = i; t.pend = p; t.ovf = v;
    vq.push_back(t);
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic apply(input logic [7:0] r, input logic [7:0] e, input logic [7:0] g,
                       input logic a);
    @(negedge clk);
    req = r; en = e; edg = g; ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; en = '0; edg = '0; ack = 1'b0;

    //    req    en     edge   ack out id    pend   ovf
    // Fixed priority with level sources: 0x81 gives 0, then 7 after ack.
    add(8'h81, 8'hFF, 8'h00, 0, 1, 3'd0, 8'h81, 8'h00);
    add(8'h80, 8'hFF, 8'h00, 1, 0, 3'd0, 8'h80, 8'h00);
    add(8'h80, 8'hFF, 8'h00, 0, 1, 3'd7, 8'h80, 8'h00);
    add(8'h80, 8'hFF, 8'h00, 1, 0, 3'd0, 8'h80, 8'h00);
    add(8'h00, 8'hFF, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00);
    // Edge pulse on IRQ3: pending after 1 cycle, presented after 2.
    add(8'h08, 8'hFF, 8'hFF, 0, 0, 3'd0, 8'h08, 8'h00);
    add(8'h00, 8'hFF, 8'hFF, 0, 1, 3'd3, 8'h08, 8'h00);
    add(8'h00, 8'hFF, 8'hFF, 1, 0, 3'd0, 8'h00, 8'h00);
    add(8'h00, 8'hFF, 8'hFF, 0, 0, 3'd0, 8'h00, 8'h00);
    // IRQ5 pulsed twice before ack: overflow, which the ack clears.
    add(8'h20, 8'hFF, 8'hFF, 0, 0, 3'd0, 8'h20, 8'h00);
    add(8'h00, 8'hFF, 8'hFF, 0, 1, 3'd5, 8'h20, 8'h00);
    add(8'h20, 8'hFF, 8'hFF, 0, 1, 3'd5, 8'h20, 8'h20);
    add(8'h00, 8'hFF, 8'hFF, 1, 0, 3'd0, 8'h00, 8'h00);
    add(8'h00, 8'hFF, 8'hFF, 0, 0, 3'd0, 8'h00, 8'h00);
    // A new edge in the same cycle as the ack: the set wins and there is no overflow.
    add(8'h20, 8'hFF, 8'hFF, 0, 0, 3'd0, 8'h20, 8'h00);
    add(8'h00, 8'hFF, 8'hFF, 0, 1, 3'd5, 8'h20, 8'h00);
    add(8'h20, 8'hFF, 8'hFF, 1, 0, 3'd0, 8'h20, 8'h00);
    add(8'h00, 8'hFF, 8'hFF, 0, 1, 3'd5, 8'h20, 8'h00);
    add(8'h00, 8'hFF, 8'hFF, 1, 0, 3'd0, 8'h00, 8'h00);
    // Masked source stays quiet; disabling the active source does not drop it.
    add(8'h01, 8'hFE, 8'h00, 0, 0, 3'd0, 8'h01, 8'h00);
    add(8'h01, 8'hFE, 8'h00, 0, 0, 3'd0, 8'h01, 8'h00);
    add(8'h04, 8'hFF, 8'h00, 0, 1, 3'd2, 8'h04, 8'h00);
    add(8'h04, 8'hFB, 8'h00, 0, 1, 3'd2, 8'h04, 8'h00);
    add(8'h00, 8'hFB, 8'h00, 0, 1, 3'd2, 8'h00, 8'h00);
    add(8'h00, 8'hFB, 8'h00, 1, 0, 3'd0, 8'h00, 8'h00);
    // An ack in IDLE must not clear a pending edge latch.
    add(8'h02, 8'hFF, 8'hFF, 1, 0, 3'd0, 8'h02, 8'h00);
    add(8'h00, 8'hFF, 8'hFF, 1, 1, 3'd1, 8'h02, 8'h00);
    add(8'h00, 8'hFF, 8'hFF, 1, 0, 3'd0, 8'h00, 8'h00);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_out",  32'(f_out),  32'(0));
    chk("rst_f_id",   32'(f_id),   32'(0));
    chk("rst_f_pend", 32'(f_pend), 32'(0));
    chk("rst_f_ovf",  32'(f_ovf),  32'(0));
    chk("rst_r_out",  32'(r_out),  32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Table vectors on the fixed-priority instance
    foreach (vq[n]) begin
      apply(vq[n].req, vq[n].en, vq[n].edg, vq[n].ack);
      chk($sformatf("vec%0d_out", n),  32'(f_out),  32'(vq[n].out));
      if (vq[n].out) begin
        chk($sformatf("vec%0d_id", n), 32'(f_id),   32'(vq[n].id));
      end
      chk($sformatf("vec%0d_pend", n), 32'(f_pend), 32'(vq[n].pend));
      chk($sformatf("vec%0d_ovf", n),  32'(f_ovf),  32'(vq[n].ovf));
    end

    // Round-robin: all level requests held, acks walk 0..7 then back to 0
    @(negedge clk);
    rst = 1'b1; req = 8'hFF; en = 8'hFF; edg = 8'h00; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      apply(8'hFF, 8'hFF, 8'h00, 1'b0);
      chk($sformatf("rr%0d_out", k), 32'(r_out), 32'(1));
      chk($sformatf("rr%0d_id", k),  32'(r_id),  32'(k % 8));
      apply(8'hFF, 8'hFF, 8'h00, 1'b1);
      chk($sformatf("rr%0d_gap", k), 32'(r_out), 32'(0));
    end

    // Asynchronous reset while ACTIVE with an overflow recorded
    @(negedge clk);
    rst = 1'b1; req = 8'h00; en = 8'hFF; edg = 8'hFF; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    apply(8'h20, 8'hFF, 8'hFF, 1'b0);
    apply(8'h00, 8'hFF, 8'hFF, 1'b0);
    apply(8'h20, 8'hFF, 8'hFF, 1'b0);
    chk("pre_rst_out", 32'(f_out), 32'(1));
    chk("pre_rst_ovf", 32'(f_ovf), 32'(8'h20));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out",  32'(f_out),  32'(0));
    chk("async_rst_pend", 32'(f_pend), 32'(0));
    chk("async_rst_ovf",  32'(f_ovf),  32'(0));
    // req stays high through reset, so it counts as a fresh edge on release.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_pend", 32'(f_pend), 32'(8'h20));
    chk("post_rst_idle", 32'(f_out),  32'(0));
    @(posedge clk);
    #1;
    chk("post_rst_out", 32'(f_out), 32'(1));
    chk("post_rst_id",  32'(f_id),  32'(5));
    apply(8'h20, 8'hFF, 8'hFF, 1'b1);
    chk("post_rst_ack", 32'(f_out), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
